gpr_file_mp: RTL and testbench
==============================

Name: gpr_file_mp

Overview:
Parametrised multi-port general register file for the dual-writeback pipeline. It provides NRD combinational read ports and two byte-enabled write ports. Same-cycle writes are forwarded to reads. A per-register pending-write scoreboard lets decode stall on RAW hazards. It sits in the ID stage: reads and issue marks come from decode, writes come from the two WB lanes.

Parameters:
DW, 32, data width in bits; must be a multiple of 8
AW, 5, address width; register count NREG = 2**AW
NRD, 3, number of read ports
CW, 2, width of each per-register pending-write counter
ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes and issues

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clock clk
rd_addr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW]
rd_data  out  NRD*DW  read data per port, forwarded
rd_busy  out  NRD  1 = register still has an outstanding write after this cycle's writebacks
we0, we1  in  1  write enables, lanes 0 and 1
wa0, wa1  in  AW  write addresses
wd0, wd1  in  DW  write data
wbe0, wbe1  in  DW/8  byte enables; a byte is written only if weN and wbeN[b] are both 1
iss_valid  in  1  decode issues an instruction that will write iss_addr
iss_addr  in  AW  destination register of the issued instruction
iss_ready  out  1  0 when the iss_addr counter is saturated
err_underflow  out  1  sticky; set when a write retires against a zero counter

Behaviour:
- Reset: all registers 0, all counters 0, err_underflow 0. A reset cycle overrides any same-cycle write or issue. Outputs are combinational from state, so every read returns 0 and every rd_busy is 0 after the reset edge.
- Read is combinational and has zero latency. Per byte b: if we1 and wbe1[b] and wa1==rd_addr, return wd1 byte. Else if we0 and wbe0[b] and wa0==rd_addr, return wd0 byte. Else return the stored byte. Lane 1 has priority.
- Write takes effect at the rising edge. The same merge rule applies, so on an overlapping address and byte, lane 1 wins. Non-enabled bytes keep their old value.
- ZERO_REG=1 and address 0:
  - reads return 0
  - writes are discarded
  - iss_valid is a no-op
  - rd_busy is 0
  - iss_ready is 1
- Scoreboard counter cnt[r], unsigned CW bits:
  - Each cycle, n_wr(r) = (we0 && wa0==r) + (we1 && wa1==r), range 0..2. A write counts as a retirement even when wbe is all zero.
  - inc = iss_valid && iss_ready && iss_addr==r.
  - Next value: cnt + inc − n_wr, computed in CW+2 bits.
  - If the result is negative, cnt becomes 0 and err_underflow is set, staying set until reset.
  - The result never exceeds 2**CW−1, because issue is gated by iss_ready.
- iss_ready = (cnt[iss_addr] − n_wr(iss_addr)) < 2**CW−1, evaluated on the current cycle's writes. A same-cycle retirement frees a slot. iss_ready does not depend on iss_valid.
- rd_busy[i] = (cnt[rd_addr_i] − n_wr(rd_addr_i)) > 0, saturated at 0. A same-cycle issue does not affect it; the issuing instruction is not its own hazard.
- iss_valid while iss_ready=0: ignored, and the counter is unchanged. Decode must hold the instruction.
- Simultaneous issue and retire on the same register: net change is +1−n_wr.
- The address inputs have no X-propagation requirement when the enables are low.

Test Plan:
1. Reset, then write lane0 wa0=3 wd0=0xDEADBEEF wbe0=4'hF. Same-cycle read of r3 returns 0xDEADBEEF. Read of r3 in the next cycle also returns 0xDEADBEEF.
2. Both lanes write wa0=wa1=5 in one cycle: wd0=0x11111111 with wbe0=4'hF, wd1=0x22222222 with wbe1=4'h3. r5 becomes 0x11112222. The forwarded read in the same cycle returns the same value.
3. Write r0=0xFFFFFFFF and issue r0. Reads of r0 return 0, rd_busy=0, counter stays 0, iss_ready=1.
4. Issue r7 three times (CW=2). A read of r7 shows rd_busy=1, and iss_ready for r7 goes 0. A fourth issue is ignored. A same-cycle lane0 write of r7 plus an issue of r7 is accepted, and the counter stays 3. Three more write cycles bring rd_busy to 0.
5. Write r9 with cnt[9]=0 gives err_underflow=1, cnt[9] stays 0, and the register is written. A later reset clears err_underflow.
6. Issue r4 and write r4=0x5 while asserting reset in the same cycle. After the edge, r4=0, cnt[4]=0, rd_busy=0.

Source files
------------

// File: rtl/gpr_file_mp.sv
// gpr_file_mp - multi-port general register file for the dual-writeback pipeline.
//
// Lives in the ID stage. Decode reads operands through NRD combinational read
// ports and marks destinations with iss_valid/iss_addr. The two WB lanes write
// back with per-byte enables. Same-cycle writes are forwarded to the read ports,
// and lane 1 has priority over lane 0 on each byte. A small per-register
// pending-write counter lets decode see RAW hazards through rd_busy, and apply
// back-pressure through iss_ready.
//
// Ports:
//   clk, reset          rising-edge clock; synchronous active-high reset
//   rd_addr/rd_data     NRD read ports, packed AW / DW bits per port
//   rd_busy             per read port: register still pending after this cycle's writebacks
//   we*/wa*/wd*/wbe*    write lanes 0 and 1 with byte enables
//   iss_valid/iss_addr  decode issues an instruction that will write iss_addr
//   iss_ready           0 when the counter for iss_addr would stay saturated
//   err_underflow       sticky: a writeback retired against a zero counter
module gpr_file_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRD      = 3,
  parameter int CW       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*DW-1:0]   rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we0,
  input  logic                we1,
  input  logic [AW-1:0]       wa0,
  input  logic [AW-1:0]       wa1,
  input  logic [DW-1:0]       wd0,
  input  logic [DW-1:0]       wd1,
  input  logic [DW/8-1:0]     wbe0,
  input  logic [DW/8-1:0]     wbe1,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  output logic                iss_ready,
  output logic                err_underflow
);

  localparam int NREG = 2**AW;
  localparam int NB   = DW/8;
  // Largest value a pending counter may hold, widened to the signed work width.
  localparam logic [CW+1:0] CNT_MAX = {2'b00, {CW{1'b1}}};

  logic [DW-1:0]   mem      [NREG];
  logic [CW-1:0]   cnt      [NREG];
  logic [CW-1:0]   cnt_next [NREG];
  logic [CW+1:0]   cnt_sum;
  logic [CW+1:0]   iss_pend;
  logic            underflow_any;
  logic            err_q;

  // Register 0 is hardwired to zero only when ZERO_REG is set.
  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Number of writebacks retiring against register a this cycle (0..2).
  // A write with all byte enables low still counts as a retirement.
  function automatic logic [1:0] n_wr(input logic [AW-1:0] a);
    return {1'b0, we0 && (wa0 == a)} + {1'b0, we1 && (wa1 == a)};
  endfunction

  // Pending count after this cycle's writebacks, in CW+2 bits so that a
  // negative result shows up in the top bit.
  function automatic logic [CW+1:0] pend_after_wb(input logic [AW-1:0] a);
    return {2'b00, cnt[a]} - {{CW{1'b0}}, n_wr(a)};
  endfunction

  function automatic logic has_pending(input logic [AW-1:0] a);
    logic [CW+1:0] p;
    p = pend_after_wb(a);
    return !p[CW+1] && (p != '0);
  endfunction

  // Byte-wise merge of the two write lanes over an old value. Lane 1 is
  // checked first, so it wins on an overlapping address and byte.
  function automatic logic [DW-1:0] merge_wb(input logic [AW-1:0] a,
                                             input logic [DW-1:0] old);
    logic [DW-1:0] v;
    v = old;
    for (int b = 0; b < NB; b++) begin
      if (we1 && wbe1[b] && (wa1 == a)) begin
        v[b*8 +: 8] = wd1[b*8 +: 8];
      end else if (we0 && wbe0[b] && (wa0 == a)) begin
        v[b*8 +: 8] = wd0[b*8 +: 8];
      end
    end
    return v;
  endfunction

  // Read ports: stored data with same-cycle writebacks forwarded, plus the
  // hazard flag. A same-cycle issue is deliberately not visible here, because
  // the issuing instruction is not its own hazard.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (!is_zero(rd_addr[i*AW +: AW])) begin
        rd_data[i*DW +: DW] = merge_wb(rd_addr[i*AW +: AW], mem[rd_addr[i*AW +: AW]]);
        rd_busy[i]          = has_pending(rd_addr[i*AW +: AW]);
      end
    end
  end

  // Issue back-pressure. A same-cycle retirement frees a slot. The result is
  // independent of iss_valid, so decode can look at it before committing.
  always_comb begin
    iss_pend  = pend_after_wb(iss_addr);
    iss_ready = is_zero(iss_addr) || iss_pend[CW+1] || (iss_pend < CNT_MAX);
  end

  // Next value of every pending counter. Going below zero clamps to zero and
  // raises the underflow flag. Going above the maximum cannot happen, because
  // issues are gated by iss_ready.
  always_comb begin
    underflow_any = 1'b0;
    cnt_sum       = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_sum = {2'b00, cnt[r]}
              + {{(CW+1){1'b0}}, (iss_valid && iss_ready && (iss_addr == AW'(r)))}
              - {{CW{1'b0}}, n_wr(AW'(r))};
      cnt_next[r] = cnt_sum[CW-1:0];
      if (cnt_sum[CW+1]) begin
        cnt_next[r] = '0;
        if (!is_zero(AW'(r))) begin
          underflow_any = 1'b1;
        end
      end
      if (is_zero(AW'(r))) begin
        cnt_next[r] = '0;
      end
    end
  end

  // State update. Reset takes priority over any same-cycle write or issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        mem[r] <= '0;
        cnt[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (!is_zero(AW'(r))) begin
          mem[r] <= merge_wb(AW'(r), mem[r]);
        end
        cnt[r] <= cnt_next[r];
      end
      if (underflow_any) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_underflow = err_q;

endmodule

// File: tb/tb_gpr_file_mp.sv
// tb_gpr_file_mp - self-checking bench for gpr_file_mp with default parameters.
// Expected values come from a behavioural reference model. Directed scenarios
// also push hand-derived constants. All expectations are queued before a cycle
// and drained against the DUT one time unit later.
module tb_gpr_file_mp;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 3;
  localparam int CW  = 2;

  localparam int K_RD0   = 0;
  localparam int K_RD1   = 1;
  localparam int K_RD2   = 2;
  localparam int K_BUSY  = 3;
  localparam int K_READY = 4;
  localparam int K_ERR   = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*DW-1:0]   rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                we0, we1;
  logic [AW-1:0]       wa0, wa1;
  logic [DW-1:0]       wd0, wd1;
  logic [DW/8-1:0]     wbe0, wbe1;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                iss_ready;
  logic                err_underflow;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  logic        m_err;

  gpr_file_mp #(.DW(DW), .AW(AW), .NRD(NRD), .CW(CW), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .wbe0(wbe0), .wbe1(wbe1),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic string kindName(input int k);
    case (k)
      K_RD0:   return "rd_data0";
      K_RD1:   return "rd_data1";
      K_RD2:   return "rd_data2";
      K_BUSY:  return "rd_busy";
      K_READY: return "iss_ready";
      default: return "err_underflow";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int k);
    case (k)
      K_RD0:   return rd_data[31:0];
      K_RD1:   return rd_data[63:32];
      K_RD2:   return rd_data[95:64];
      K_BUSY:  return {29'b0, rd_busy};
      K_READY: return {31'b0, iss_ready};
      default: return {31'b0, err_underflow};
    endcase
  endfunction

  // Reference model: what a read of a returns this cycle, with forwarding.
  function automatic logic [31:0] mRead(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0) return 32'd0;
    v = m_regs[a];
    for (int b = 0; b < 4; b++) begin
      if (we1 && wbe1[b] && wa1 == a)      v[b*8 +: 8] = wd1[b*8 +: 8];
      else if (we0 && wbe0[b] && wa0 == a) v[b*8 +: 8] = wd0[b*8 +: 8];
    end
    return v;
  endfunction

  function automatic int mNwr(input logic [4:0] a);
    int n;
    n = 0;
    if (we0 && wa0 == a) n++;
    if (we1 && wa1 == a) n++;
    return n;
  endfunction

  function automatic logic mBusy(input logic [4:0] a);
    return (a != 5'd0) && ((m_cnt[a] - mNwr(a)) > 0);
  endfunction

  function automatic logic mReady();
    return (iss_addr == 5'd0) || ((m_cnt[iss_addr] - mNwr(iss_addr)) < 3);
  endfunction

  task automatic pushExp(input int k, input logic [31:0] v);
    exp_t e;
    e.kind = 3'(k);
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic setRd(input int p, input logic [4:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic idleInputs();
    reset     = 1'b0;
    we0       = 1'b0;
    we1       = 1'b0;
    wa0       = '0;
    wa1       = '0;
    wd0       = '0;
    wd1       = '0;
    wbe0      = '0;
    wbe1      = '0;
    iss_valid = 1'b0;
    iss_addr  = '0;
  endtask

  // Advance the model by one rising edge, using the inputs held across it.
  task automatic modelUpdate();
    logic [31:0] nr [32];
    int          nc [32];
    logic        rdy;
    int          c;
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = 32'd0;
        m_cnt[r]  = 0;
      end
      m_err = 1'b0;
    end else begin
      rdy = mReady();
      nr[0] = 32'd0;
      nc[0] = 0;
      for (int r = 1; r < 32; r++) begin
        nr[r] = mRead(5'(r));
        c = m_cnt[r] + ((iss_valid && rdy && iss_addr == 5'(r)) ? 1 : 0) - mNwr(5'(r));
        if (c < 0) begin
          c = 0;
          m_err = 1'b1;
        end
        nc[r] = c;
      end
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = nr[r];
        m_cnt[r]  = nc[r];
      end
    end
  endtask

  // One cycle: queue model expectations behind any directed ones, compare,
  // clock the edge, advance the model, and return at the next falling edge.
  task automatic applyStimulus();
    logic [2:0] busy;
    exp_t       e;
    for (int i = 0; i < NRD; i++) begin
      pushExp(i, mRead(rd_addr[i*AW +: AW]));
      busy[i] = mBusy(rd_addr[i*AW +: AW]);
    end
    pushExp(K_BUSY, {29'b0, busy});
    pushExp(K_READY, {31'b0, mReady()});
    pushExp(K_ERR, {31'b0, m_err});
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput(kindName(int'(e.kind)), observe(int'(e.kind)), e.val);
    end
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  initial begin
    idleInputs();
    rd_addr = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    modelUpdate();
    @(negedge clk);

    // Reset state.
    idleInputs();
    setRd(0, 5'd3); setRd(1, 5'd5); setRd(2, 5'd7);
    iss_addr = 5'd7;
    pushExp(K_RD0, 32'd0); pushExp(K_RD1, 32'd0);
    pushExp(K_BUSY, 32'd0); pushExp(K_READY, 32'd1); pushExp(K_ERR, 32'd0);
    applyStimulus();

    // Lane 0 write, forwarded in the same cycle and stored for the next one.
    idleInputs();
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEADBEEF; wbe0 = 4'hF;
    setRd(0, 5'd3);
    pushExp(K_RD0, 32'hDEADBEEF);
    applyStimulus();
    idleInputs();
    pushExp(K_RD0, 32'hDEADBEEF);
    applyStimulus();

    // Both lanes hit r5, and lane 1 owns the low two bytes.
    idleInputs();
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h11111111; wbe0 = 4'hF;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h22222222; wbe1 = 4'h3;
    setRd(1, 5'd5);
    pushExp(K_RD1, 32'h11112222);
    applyStimulus();
    idleInputs();
    pushExp(K_RD1, 32'h11112222);
    applyStimulus();

    // r0 ignores writes and issues.
    idleInputs();
    setRd(0, 5'd0); setRd(1, 5'd0); setRd(2, 5'd0);
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; wbe0 = 4'hF;
    iss_valid = 1'b1; iss_addr = 5'd0;
    pushExp(K_RD0, 32'd0); pushExp(K_BUSY, 32'd0); pushExp(K_READY, 32'd1);
    applyStimulus();
    idleInputs();
    pushExp(K_RD0, 32'd0); pushExp(K_BUSY, 32'd0); pushExp(K_READY, 32'd1);
    applyStimulus();

    // Saturate r7, then check that a same-cycle retire frees one slot.
    setRd(0, 5'd7); setRd(1, 5'd1); setRd(2, 5'd2);
    for (int k = 0; k < 3; k++) begin
      idleInputs();
      iss_valid = 1'b1; iss_addr = 5'd7;
      pushExp(K_READY, 32'd1);
      pushExp(K_BUSY, (k == 0) ? 32'd0 : 32'd1);
      applyStimulus();
    end
    idleInputs();
    iss_valid = 1'b1; iss_addr = 5'd7;
    pushExp(K_BUSY, 32'd1); pushExp(K_READY, 32'd0);
    applyStimulus();
    idleInputs();
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h00000077; wbe0 = 4'hF;
    iss_valid = 1'b1; iss_addr = 5'd7;
    pushExp(K_READY, 32'd1); pushExp(K_BUSY, 32'd1);
    applyStimulus();
    idleInputs();
    iss_addr = 5'd7;
    pushExp(K_READY, 32'd0); pushExp(K_BUSY, 32'd1);
    applyStimulus();
    for (int k = 0; k < 3; k++) begin
      idleInputs();
      we0 = 1'b1; wa0 = 5'd7; wd0 = 32'(k); wbe0 = 4'h1;
      iss_addr = 5'd7;
      pushExp(K_BUSY, (k == 2) ? 32'd0 : 32'd1);
      applyStimulus();
    end
    idleInputs();
    iss_addr = 5'd7;
    pushExp(K_BUSY, 32'd0); pushExp(K_READY, 32'd1);
    applyStimulus();

    // Underflow on r9: the flag sets, the data is still written, and reset clears the flag.
    idleInputs();
    reset = 1'b1;
    applyStimulus();
    idleInputs();
    pushExp(K_ERR, 32'd0);
    applyStimulus();
    idleInputs();
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hCAFE0009; wbe0 = 4'hF;
    setRd(0, 5'd9);
    pushExp(K_RD0, 32'hCAFE0009); pushExp(K_ERR, 32'd0);
    applyStimulus();
    idleInputs();
    pushExp(K_ERR, 32'd1); pushExp(K_RD0, 32'hCAFE0009);
    applyStimulus();
    idleInputs();
    reset = 1'b1;
    applyStimulus();
    idleInputs();
    pushExp(K_ERR, 32'd0); pushExp(K_RD0, 32'd0);
    applyStimulus();

    // Reset overrides a same-cycle issue and write.
    idleInputs();
    reset = 1'b1;
    iss_valid = 1'b1; iss_addr = 5'd4;
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h5; wbe0 = 4'hF;
    setRd(0, 5'd4);
    applyStimulus();
    idleInputs();
    iss_addr = 5'd4;
    pushExp(K_RD0, 32'd0); pushExp(K_BUSY, 32'd0); pushExp(K_READY, 32'd1);
    applyStimulus();

    // Random traffic on a small address window, checked against the model.
    for (int k = 0; k < 300; k++) begin
      idleInputs();
      we0       = 1'($urandom_range(0, 1));
      we1       = 1'($urandom_range(0, 1));
      wa0       = 5'($urandom_range(0, 7));
      wa1       = 5'($urandom_range(0, 7));
      wd0       = 32'($urandom);
      wd1       = 32'($urandom);
      wbe0      = 4'($urandom);
      wbe1      = 4'($urandom);
      iss_valid = 1'($urandom_range(0, 1));
      iss_addr  = 5'($urandom_range(0, 7));
      for (int p = 0; p < NRD; p++) setRd(p, 5'($urandom_range(0, 7)));
      reset = ($urandom_range(0, 99) == 0);
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
